// File: rtl/spi_ram_slave_p_if.sv
// ---------------------------------------------------------------------------
// spi_ram_slave_p_if
// Serial link between a frame master and the spi_ram_slave_p RAM slave.
//   SS_n : active-low slave select, frames one transaction
//   MOSI : serial command/payload bits, MSB first
//   MISO : serial read data, MSB first (driven by the slave)
//   busy : slave is inside a transaction (driven by the slave)
// ---------------------------------------------------------------------------
interface spi_ram_slave_p_if;
    logic SS_n;
    logic MOSI;
    logic MISO;
    logic busy;

    modport master (output SS_n, output MOSI, input MISO, input busy);
    modport slave  (input SS_n, input MOSI, output MISO, output busy);
endinterface

// File: rtl/spi_ram_slave_p.sv
// ---------------------------------------------------------------------------
// spi_ram_slave_p
// Serial slave in front of a single-port RAM. Each frame is 2 command bits
// followed by DATA_WIDTH payload bits, MSB first, sampled on rising clk while
// SS_n is low:
//   00 set write address   01 write payload to mem[wr_addr]
//   10 set read address    11 read mem[rd_addr] and shift it out on MISO
// Out-of-range writes are dropped and out-of-range reads return zero.
// RAM contents survive reset.
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : spi_ram_slave_p_if.slave (SS_n, MOSI in; MISO, busy out)
//
// Parameters: DATA_WIDTH (payload bits, >= 2), MEM_DEPTH (2..2**DATA_WIDTH)
//
// Optional feature macro SPI_RAM_AUTO_INC_EN: when defined, wr_addr advances
// after every in-range write and rd_addr after every completed in-range
// read, wrapping MEM_DEPTH-1 -> 0.
// ---------------------------------------------------------------------------
module spi_ram_slave_p #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_ram_slave_p_if.slave bus
);

    localparam int FRAME_W = DATA_WIDTH + 2;
    localparam int AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CW      = $clog2(FRAME_W + 1);

    localparam logic [CW-1:0]         ZERO_C  = {CW{1'b0}};
    localparam logic [CW-1:0]         ONE_C   = CW'(1);
    localparam logic [CW-1:0]         LAST_RX = CW'(FRAME_W - 1);
    localparam logic [CW-1:0]         LAST_TX = CW'(DATA_WIDTH);
    localparam logic [DATA_WIDTH:0]   DEPTH_L = (DATA_WIDTH + 1)'(MEM_DEPTH);

    localparam logic [1:0] CMD_WADDR = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_RADDR = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RECV    = 3'd1,
        RD_WAIT = 3'd2,
        TX      = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Address lies inside the implemented RAM
    function automatic logic in_range(input logic [DATA_WIDTH-1:0] addr);
        return ({1'b0, addr} < DEPTH_L);
    endfunction

`ifdef SPI_RAM_AUTO_INC_EN
    // Next sequential address, wrapping at the top of the RAM
    function automatic logic [DATA_WIDTH-1:0] next_addr(input logic [DATA_WIDTH-1:0] addr);
        logic [DATA_WIDTH:0] last;
        last = DEPTH_L - (DATA_WIDTH + 1)'(1);
        if ({1'b0, addr} == last) begin
            return {DATA_WIDTH{1'b0}};
        end else begin
            return addr + DATA_WIDTH'(1);
        end
    endfunction
`endif

    state_t                  state_r, state_next_s;
    logic [CW-1:0]           cnt_r, cnt_next_s;
    logic [FRAME_W-2:0]      shift_r, shift_next_s;
    logic [DATA_WIDTH-1:0]   wr_addr_r, wr_addr_next_s;
    logic [DATA_WIDTH-1:0]   rd_addr_r, rd_addr_next_s;
    logic                    miso_r, miso_next_s;
    logic                    busy_r;
    logic [DATA_WIDTH-1:0]   rd_word_r;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    logic                    mem_we_s;
    logic                    mem_re_s;
    logic [FRAME_W-1:0]      frame_s;
    logic [1:0]              cmd_s;
    logic [DATA_WIDTH-1:0]   payload_s;
    logic [DATA_WIDTH-1:0]   tx_word_s;
    logic                    wr_in_range_s;
    logic                    rd_in_range_s;

    // The frame as it stands once the bit on MOSI is shifted in
    assign frame_s       = {shift_r, bus.MOSI};
    assign cmd_s         = frame_s[FRAME_W-1:DATA_WIDTH];
    assign payload_s     = frame_s[DATA_WIDTH-1:0];
    assign wr_in_range_s = in_range(wr_addr_r);
    assign rd_in_range_s = in_range(rd_addr_r);
    // First TX bit comes straight from the RAM word; later bits from shift_r
    assign tx_word_s     = (cnt_r == ZERO_C) ? rd_word_r : shift_r[DATA_WIDTH-1:0];

    assign bus.MISO = miso_r;
    assign bus.busy = busy_r;

    // Next-state, datapath and RAM-strobe decode
    always_comb begin
        state_next_s   = state_r;
        cnt_next_s     = cnt_r;
        shift_next_s   = shift_r;
        wr_addr_next_s = wr_addr_r;
        rd_addr_next_s = rd_addr_r;
        miso_next_s    = 1'b0;
        mem_we_s       = 1'b0;
        mem_re_s       = 1'b0;

        case (state_r)
            IDLE: begin
                if (!bus.SS_n) begin
                    state_next_s = RECV;
                    cnt_next_s   = ZERO_C;
                    shift_next_s = '0;
                end else begin
                    state_next_s = IDLE;
                end
            end

            RECV: begin
                if (bus.SS_n) begin
                    state_next_s = IDLE;
                end else if (cnt_r == LAST_RX) begin
                    case (cmd_s)
                        CMD_WADDR: begin
                            wr_addr_next_s = payload_s;
                            state_next_s   = DONE;
                        end
                        CMD_WRITE: begin
                            mem_we_s = wr_in_range_s;
`ifdef SPI_RAM_AUTO_INC_EN
                            if (wr_in_range_s) begin
                                wr_addr_next_s = next_addr(wr_addr_r);
                            end else begin
                                wr_addr_next_s = wr_addr_r;
                            end
`endif
                            state_next_s = DONE;
                        end
                        CMD_RADDR: begin
                            rd_addr_next_s = payload_s;
                            state_next_s   = DONE;
                        end
                        CMD_READ: begin
                            state_next_s = RD_WAIT;
                        end
                        default: begin
                            state_next_s = DONE;
                        end
                    endcase
                end else begin
                    cnt_next_s   = cnt_r + ONE_C;
                    shift_next_s = frame_s[FRAME_W-2:0];
                end
            end

            RD_WAIT: begin
                if (bus.SS_n) begin
                    state_next_s = IDLE;
                end else begin
                    mem_re_s     = 1'b1;
                    cnt_next_s   = ZERO_C;
                    state_next_s = TX;
                end
            end

            TX: begin
                if (bus.SS_n) begin
                    state_next_s = IDLE;
                end else if (cnt_r == LAST_TX) begin
                    // Last bit has had its full cycle on MISO; only now is the read complete
                    state_next_s = DONE;
`ifdef SPI_RAM_AUTO_INC_EN
                    if (rd_in_range_s) begin
                        rd_addr_next_s = next_addr(rd_addr_r);
                    end else begin
                        rd_addr_next_s = rd_addr_r;
                    end
`endif
                end else begin
                    miso_next_s  = tx_word_s[DATA_WIDTH-1];
                    shift_next_s = {1'b0, tx_word_s[DATA_WIDTH-2:0], 1'b0};
                    cnt_next_s   = cnt_r + ONE_C;
                end
            end

            DONE: begin
                if (bus.SS_n) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end

            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= ZERO_C;
            shift_r   <= '0;
            wr_addr_r <= {DATA_WIDTH{1'b0}};
            rd_addr_r <= {DATA_WIDTH{1'b0}};
            miso_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            cnt_r     <= cnt_next_s;
            shift_r   <= shift_next_s;
            wr_addr_r <= wr_addr_next_s;
            rd_addr_r <= rd_addr_next_s;
            miso_r    <= miso_next_s;
            busy_r    <= (state_next_s != IDLE);
        end
    end

    // Single-port RAM; write (decode edge) and read (RD_WAIT) never coincide
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[wr_addr_r[AW-1:0]] <= payload_s;
        end
        if (mem_re_s) begin
            rd_word_r <= rd_in_range_s ? mem[rd_addr_r[AW-1:0]] : {DATA_WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_spi_ram_slave_p.sv
// Self-checking bench: two slaves (MEM_DEPTH 256 and 200) share one serial
// stimulus; a behavioural model of both RAMs predicts every read word.
module tb_spi_ram_slave_p;

`ifdef SPI_RAM_AUTO_INC_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic ss_n;
    logic mosi;
    logic miso0, miso1, busy0, busy1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] mem_m [2][256];
    int         wr_m  [2];
    int         rd_m  [2];

    always #5 clk = ~clk;

    spi_ram_slave_p_if bus0 ();
    spi_ram_slave_p_if bus1 ();

    assign bus0.SS_n = ss_n;
    assign bus0.MOSI = mosi;
    assign bus1.SS_n = ss_n;
    assign bus1.MOSI = mosi;
    assign miso0 = bus0.MISO;
    assign busy0 = bus0.busy;
    assign miso1 = bus1.MISO;
    assign busy1 = bus1.busy;

    spi_ram_slave_p #(.DATA_WIDTH(8), .MEM_DEPTH(256)) dut (.clk(clk), .rst_n(rst_n), .bus(bus0));
    spi_ram_slave_p #(.DATA_WIDTH(8), .MEM_DEPTH(200)) dut200 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // Reference: apply one complete frame to both RAM models
    task automatic model_apply(input logic [1:0] cmd, input logic [7:0] pl,
                               output logic [7:0] e0, output logic [7:0] e1);
        logic [7:0] e [2];
        int d;
        for (int k = 0; k < 2; k++) begin
            d = (k == 0) ? 256 : 200;
            e[k] = 8'h00;
            case (cmd)
                2'b00: wr_m[k] = int'(pl);
                2'b01: if (wr_m[k] < d) begin
                    mem_m[k][wr_m[k]] = pl;
                    if (AUTO) wr_m[k] = (wr_m[k] + 1) % d;
                end
                2'b10: rd_m[k] = int'(pl);
                default: if (rd_m[k] < d) begin
                    e[k] = mem_m[k][rd_m[k]];
                    if (AUTO) rd_m[k] = (rd_m[k] + 1) % d;
                end
            endcase
        end
        e0 = e[0];
        e1 = e[1];
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            wr_m[k] = 0;
            rd_m[k] = 0;
        end
    endtask

    // Drive one full frame; collect read words and quiet/idle observations
    task automatic send_frame(input logic [1:0] cmd, input logic [7:0] pl,
                              output logic [7:0] w0, output logic [7:0] w1,
                              output bit quiet, output bit idle);
        logic [9:0] f;
        f = {cmd, pl};
        quiet = 1'b1;
        w0 = 8'h00;
        w1 = 8'h00;
        @(negedge clk);
        ss_n = 1'b0;
        mosi = 1'($urandom);
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk);
            if (miso0 !== 1'b0 || miso1 !== 1'b0 || busy0 !== 1'b1 || busy1 !== 1'b1) quiet = 1'b0;
            mosi = f[i];
        end
        @(negedge clk);
        if (miso0 !== 1'b0 || miso1 !== 1'b0 || busy0 !== 1'b1 || busy1 !== 1'b1) quiet = 1'b0;
        mosi = 1'($urandom);
        if (cmd == 2'b11) begin
            @(negedge clk);
            if (miso0 !== 1'b0 || miso1 !== 1'b0 || busy0 !== 1'b1 || busy1 !== 1'b1) quiet = 1'b0;
            for (int i = 7; i >= 0; i--) begin
                @(negedge clk);
                w0[i] = miso0;
                w1[i] = miso1;
                if (busy0 !== 1'b1 || busy1 !== 1'b1) quiet = 1'b0;
                mosi = 1'($urandom);
            end
            @(negedge clk);
            if (miso0 !== 1'b0 || miso1 !== 1'b0 || busy0 !== 1'b1 || busy1 !== 1'b1) quiet = 1'b0;
        end
        ss_n = 1'b1;
        @(negedge clk);
        idle = (busy0 === 1'b0 && busy1 === 1'b0 && miso0 === 1'b0 && miso1 === 1'b0);
    endtask

    // Model update followed by the matching frame on the wire
    task automatic do_frame(input logic [1:0] cmd, input logic [7:0] pl,
                            output logic [7:0] w0, output logic [7:0] w1,
                            output logic [7:0] e0, output logic [7:0] e1,
                            output bit quiet, output bit idle);
        model_apply(cmd, pl, e0, e1);
        send_frame(cmd, pl, w0, w1, quiet, idle);
    endtask

    // Drive n bits of a frame (random beyond the 10th) then raise SS_n
    task automatic send_abort(input logic [1:0] cmd, input logic [7:0] pl, input int n,
                              output bit idle);
        logic [9:0] f;
        f = {cmd, pl};
        @(negedge clk);
        ss_n = 1'b0;
        mosi = 1'($urandom);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mosi = (i < 10) ? f[9 - i] : 1'($urandom);
        end
        @(negedge clk);
        ss_n = 1'b1;
        @(negedge clk);
        idle = (busy0 === 1'b0 && busy1 === 1'b0 && miso0 === 1'b0 && miso1 === 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ss_n  = 1'b1;
        mosi  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (miso0 !== 1'b0) $display("FAIL reset_miso0: got %b expected 0", miso0); else n_pass++;
        n_checks++; if (busy0 !== 1'b0) $display("FAIL reset_busy0: got %b expected 0", busy0); else n_pass++;
        n_checks++; if (miso1 !== 1'b0) $display("FAIL reset_miso1: got %b expected 0", miso1); else n_pass++;
        n_checks++; if (busy1 !== 1'b0) $display("FAIL reset_busy1: got %b expected 0", busy1); else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (busy0 !== 1'b0 || busy1 !== 1'b0)
            $display("FAIL idle_busy: got %b%b expected 00", busy0, busy1); else n_pass++;
    endtask

    // Give every RAM location a known value
    task automatic fill_ram();
        logic [7:0] w0, w1, e0, e1;
        bit q, id;
        for (int a = 0; a < 256; a++) begin
            do_frame(2'b00, 8'(a), w0, w1, e0, e1, q, id);
            do_frame(2'b01, 8'($urandom), w0, w1, e0, e1, q, id);
        end
    endtask

    task automatic test_directed();
        logic [7:0] w0, w1, e0, e1;
        bit q, id;
        do_frame(2'b00, 8'hFA, w0, w1, e0, e1, q, id);
        do_frame(2'b01, 8'hAF, w0, w1, e0, e1, q, id);
        do_frame(2'b10, 8'hFA, w0, w1, e0, e1, q, id);
        do_frame(2'b11, 8'h33, w0, w1, e0, e1, q, id);
        n_checks++; if (w0 !== 8'hAF) $display("FAIL dir_read_fa: got %h expected af", w0); else n_pass++;
        n_checks++; if (w0 !== e0) $display("FAIL dir_read_fa_model: got %h expected %h", w0, e0); else n_pass++;
        n_checks++; if (w1 !== 8'h00) $display("FAIL dir_read_fa_d200: got %h expected 00", w1); else n_pass++;
        n_checks++; if (!q) $display("FAIL dir_quiet: got 0 expected 1"); else n_pass++;
        n_checks++; if (!id) $display("FAIL dir_idle: got 0 expected 1"); else n_pass++;
        do_frame(2'b00, 8'hF0, w0, w1, e0, e1, q, id);
        do_frame(2'b01, 8'hAA, w0, w1, e0, e1, q, id);
        do_frame(2'b10, 8'hF0, w0, w1, e0, e1, q, id);
        do_frame(2'b11, 8'h00, w0, w1, e0, e1, q, id);
        n_checks++; if (w0 !== 8'hAA) $display("FAIL dir_read_f0: got %h expected aa", w0); else n_pass++;
        n_checks++; if (w1 !== 8'h00) $display("FAIL dir_read_f0_d200: got %h expected 00", w1); else n_pass++;
        n_checks++; if (w1 !== e1) $display("FAIL dir_read_f0_model: got %h expected %h", w1, e1); else n_pass++;
    endtask

    task automatic test_auto_inc();
        logic [7:0] w0, w1, e0, e1, ra0, ra1, ea1;
        bit q, id;
        do_frame(2'b00, 8'hFF, w0, w1, e0, e1, q, id);
        do_frame(2'b01, 8'h11, w0, w1, e0, e1, q, id);
        do_frame(2'b01, 8'h22, w0, w1, e0, e1, q, id);
        do_frame(2'b10, 8'hFF, w0, w1, e0, e1, q, id);
        do_frame(2'b11, 8'h5A, ra0, ra1, e0, e1, q, id);
        n_checks++; if (ra0 !== e0) $display("FAIL inc_read1: got %h expected %h", ra0, e0); else n_pass++;
        n_checks++; if (ra1 !== e1) $display("FAIL inc_read1_d200: got %h expected %h", ra1, e1); else n_pass++;
        do_frame(2'b11, 8'hA5, w0, w1, e0, ea1, q, id);
        n_checks++; if (w0 !== e0) $display("FAIL inc_read2: got %h expected %h", w0, e0); else n_pass++;
        n_checks++; if (w1 !== ea1) $display("FAIL inc_read2_d200: got %h expected %h", w1, ea1); else n_pass++;
`ifdef SPI_RAM_AUTO_INC_EN
        n_checks++; if (ra0 !== 8'h11 || w0 !== 8'h22)
            $display("FAIL inc_words: got %h %h expected 11 22", ra0, w0); else n_pass++;
`else
        n_checks++; if (ra0 !== 8'h22 || w0 !== 8'h22)
            $display("FAIL noinc_words: got %h %h expected 22 22", ra0, w0); else n_pass++;
        do_frame(2'b00, 8'h05, w0, w1, e0, e1, q, id);
        do_frame(2'b01, 8'h11, w0, w1, e0, e1, q, id);
        do_frame(2'b01, 8'h22, w0, w1, e0, e1, q, id);
        do_frame(2'b10, 8'h05, w0, w1, e0, e1, q, id);
        do_frame(2'b11, 8'h00, ra0, ra1, e0, e1, q, id);
        do_frame(2'b11, 8'h00, w0, w1, e0, e1, q, id);
        n_checks++; if (ra0 !== 8'h22 || w0 !== 8'h22)
            $display("FAIL noinc_addr5: got %h %h expected 22 22", ra0, w0); else n_pass++;
        do_frame(2'b10, 8'h06, w0, w1, e0, e1, q, id);
        do_frame(2'b11, 8'h00, w0, w1, e0, e1, q, id);
        n_checks++; if (w0 !== e0) $display("FAIL noinc_addr6: got %h expected %h", w0, e0); else n_pass++;
`endif
    endtask

    task automatic test_abort();
        logic [7:0] w0, w1, e0, e1;
        bit q, id;
        int n;
        logic [1:0] c;
        do_frame(2'b00, 8'h10, w0, w1, e0, e1, q, id);
        do_frame(2'b01, 8'h00, w0, w1, e0, e1, q, id);
        do_frame(2'b00, 8'h10, w0, w1, e0, e1, q, id);
        send_abort(2'b01, 8'h55, 5, id);
        n_checks++; if (!id) $display("FAIL abort5_idle: got 0 expected 1"); else n_pass++;
        do_frame(2'b10, 8'h10, w0, w1, e0, e1, q, id);
        do_frame(2'b11, 8'h00, w0, w1, e0, e1, q, id);
        n_checks++; if (w0 !== 8'h00) $display("FAIL abort5_mem: got %h expected 00", w0); else n_pass++;
        for (int t = 0; t < 24; t++) begin
            c = 2'($urandom);
            n = (c == 2'b11) ? $urandom_range(1, 19) : $urandom_range(1, 9);
            send_abort(c, 8'($urandom), n, id);
            n_checks++; if (!id) $display("FAIL abort_idle: got 0 expected 1 (cmd %0d bits %0d)", c, n); else n_pass++;
            do_frame(2'b11, 8'h00, w0, w1, e0, e1, q, id);
            n_checks++; if (w0 !== e0 || w1 !== e1)
                $display("FAIL abort_read: got %h %h expected %h %h", w0, w1, e0, e1); else n_pass++;
            do_frame(2'b10, 8'(wr_m[0]), w0, w1, e0, e1, q, id);
            do_frame(2'b11, 8'h00, w0, w1, e0, e1, q, id);
            n_checks++; if (w0 !== e0 || w1 !== e1)
                $display("FAIL abort_wloc: got %h %h expected %h %h", w0, w1, e0, e1); else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [7:0] w0, w1, e0, e1;
        bit q, id;
        logic [1:0] c;
        for (int t = 0; t < 300; t++) begin
            c = 2'($urandom);
            do_frame(c, 8'($urandom), w0, w1, e0, e1, q, id);
            n_checks++; if (!q || !id) $display("FAIL rnd_ctrl: got quiet %b idle %b expected 1 1", q, id); else n_pass++;
            if (c == 2'b11) begin
                n_checks++; if (w0 !== e0) $display("FAIL rnd_read: got %h expected %h", w0, e0); else n_pass++;
                n_checks++; if (w1 !== e1) $display("FAIL rnd_read_d200: got %h expected %h", w1, e1); else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] w0, w1, e0, e1, a, v;
        logic [9:0] f;
        bit q, id;
        int k;
        // Reset while a read word is on MISO
        do_frame(2'b10, 8'($urandom), w0, w1, e0, e1, q, id);
        f = {2'b11, 8'h00};
        k = $urandom_range(1, 8);
        @(negedge clk);
        ss_n = 1'b0;
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk);
            mosi = f[i];
        end
        repeat (2 + k) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (miso0 !== 1'b0 || miso1 !== 1'b0)
            $display("FAIL rst_tx_miso: got %b%b expected 00", miso0, miso1); else n_pass++;
        n_checks++; if (busy0 !== 1'b0 || busy1 !== 1'b0)
            $display("FAIL rst_tx_busy: got %b%b expected 00", busy0, busy1); else n_pass++;
        ss_n = 1'b1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        do_frame(2'b11, 8'h00, w0, w1, e0, e1, q, id);
        n_checks++; if (w0 !== e0 || w1 !== e1)
            $display("FAIL rst_read0: got %h %h expected %h %h", w0, w1, e0, e1); else n_pass++;
        // Reset in the middle of a write frame leaves the RAM alone
        a = 8'($urandom_range(0, 199));
        v = mem_m[0][a] ^ 8'hFF;
        do_frame(2'b00, a, w0, w1, e0, e1, q, id);
        f = {2'b01, v};
        @(negedge clk);
        ss_n = 1'b0;
        for (int i = 9; i >= 4; i--) begin
            @(negedge clk);
            mosi = f[i];
        end
        #2;
        rst_n = 1'b0;
        ss_n  = 1'b1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        do_frame(2'b10, a, w0, w1, e0, e1, q, id);
        do_frame(2'b11, 8'h00, w0, w1, e0, e1, q, id);
        n_checks++; if (w0 !== e0 || w1 !== e1)
            $display("FAIL rst_wr_mem: got %h %h expected %h %h", w0, w1, e0, e1); else n_pass++;
    endtask

    initial begin
        #(3_000_000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        fill_ram();
        test_directed();
        test_auto_inc();
        test_abort();
        test_random();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
